// File: rtl/fb_swap_ctrl.sv
// Double-buffered framebuffer swap controller: routes processor writes to the back bank and
// swaps banks on vsync after a frame-done edge. Define FB_CLEAR_EN to clear the new back bank.
module fb_swap_ctrl #(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned PIX_LIMIT   = 76800,
  parameter logic [31:0] CLEAR_COLOR = 32'h0000_0000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              bb_we,
  input  logic [31:0]       din,
  input  logic [31:0]       waddr,
  input  logic              done,
  input  logic              vsync,
  output logic              swap,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              front_sel,
  output logic [15:0]       drop_cnt
);

`ifdef FB_CLEAR_EN
  typedef enum logic [1:0] {StDraw, StWaitVsync, StClear, StAck} state_e;
  logic [ADDR_W-1:0] clr_cnt;
`else
  typedef enum logic [1:0] {StDraw, StWaitVsync, StAck} state_e;
  logic unused_clear_color;
  assign unused_clear_color = ^CLEAR_COLOR;
`endif

  state_e state;
  logic   done_q, vsync_q;
  logic   done_edge, vsync_edge;
  logic   in_range, wr_ok;

  assign done_edge  = done & ~done_q;
  assign vsync_edge = vsync & ~vsync_q;
  assign in_range   = ({1'b0, waddr[ADDR_W-1:0]} < (ADDR_W+1)'(PIX_LIMIT)) &&
                      ((waddr >> ADDR_W) == 32'd0);
  assign wr_ok      = bb_we && in_range && (state == StDraw);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= StDraw;
      done_q    <= 1'b0;
      vsync_q   <= 1'b0;
      front_sel <= 1'b0;
      swap      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      drop_cnt  <= 16'd0;
`ifdef FB_CLEAR_EN
      clr_cnt   <= '0;
`endif
    end else begin
      done_q  <= done;
      vsync_q <= vsync;
      mem_we  <= 1'b0;
      swap    <= 1'b0;
      if (bb_we && !wr_ok && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      case (state)
        StDraw: begin
          if (wr_ok) begin
            mem_we    <= 1'b1;
            mem_addr  <= {~front_sel, waddr[ADDR_W-1:0]};
            mem_wdata <= din;
          end
          // Vsync edges here are ignored; the history register still advances, so a vsync
          // coincident with done is not seen again in StWaitVsync.
          if (done_edge) state <= StWaitVsync;
        end
        StWaitVsync: begin
          if (vsync_edge) begin
            front_sel <= ~front_sel;
`ifdef FB_CLEAR_EN
            state     <= StClear;
`else
            state     <= StAck;
`endif
          end
        end
`ifdef FB_CLEAR_EN
        StClear: begin
          // front_sel already holds the new front bank here.
          mem_we    <= 1'b1;
          mem_addr  <= {~front_sel, clr_cnt};
          mem_wdata <= CLEAR_COLOR;
          if (clr_cnt == ADDR_W'(PIX_LIMIT - 1)) begin
            clr_cnt <= '0;
            state   <= StAck;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
`endif
        StAck: begin
          swap  <= 1'b1;
          state <= StDraw;
        end
        default: state <= StDraw;
      endcase
    end
  end

endmodule
